// File: rtl/multicycle_control.sv
// Moore control FSM that sequences the multicycle datapath through fetch/decode/execute/memory/writeback.
// Optional build macro CTRL_SINGLE_STEP_EN adds a step input and a STEP_WAIT gate ahead of every FETCH.
module multicycle_control #(
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [1:0] BR_COND = 2'b01
) (
  input  logic       CLK,
  input  logic       reset_n,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] op,
  input  logic [1:0] cmpRst,
  output logic [1:0] numBits,
  output logic [1:0] immShift,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       writeEnable,
  output logic       DOrS,
  output logic       memEnableWrite,
  output logic       memEnableRead,
  output logic       PCWriteEnable,
  output logic       PCSource,
  output logic       memAddrSel,
  output logic [2:0] ALUOp,
  output logic [2:0] regDataWrite,
  output logic       halted,
  output logic [3:0] state_dbg
);

  // Five bits so STEP_WAIT fits and spare encodings exist to recover from.
  typedef enum logic [4:0] {
    IDLE      = 5'd0,
    FETCH     = 5'd1,
    DECODE    = 5'd2,
    EXEC_R    = 5'd3,
    EXEC_I    = 5'd4,
    WB_ALU    = 5'd5,
    WB_IMM    = 5'd6,
    MEM_ADDR  = 5'd7,
    MEM_READ  = 5'd8,
    WB_MEM    = 5'd9,
    MEM_WRITE = 5'd10,
    WB_CMP    = 5'd11,
    BRANCH    = 5'd12,
    JUMP_LINK = 5'd13,
    PC_LOAD   = 5'd14,
    HALT      = 5'd15,
    STEP_WAIT = 5'd16
  } state_t;

  state_t     state, next;
  state_t     resume;
  logic [3:0] op_q;
  logic       go;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) step_q <= 1'b0;
    else          step_q <= step;
  end

  assign resume = STEP_WAIT;
  assign go     = step & ~step_q;
`else
  assign resume = FETCH;
  assign go     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= next;
      if (state == DECODE) op_q <= op;
    end
  end

  // STEP_WAIT aliases IDLE in the 4-bit debug view.
  assign state_dbg = state[3:0];

  always_comb begin
    next = IDLE;
    unique case (state)
      IDLE:      next = resume;
      STEP_WAIT: next = go ? FETCH : STEP_WAIT;
      FETCH:     next = DECODE;
      DECODE: begin
        if (op == HALT_OP)      next = HALT;
        else if (op < 4'd8)     next = EXEC_R;
        else begin
          case (op)
            4'd8:         next = EXEC_I;
            4'd9:         next = WB_IMM;
            4'd10, 4'd11: next = MEM_ADDR;
            4'd12:        next = WB_CMP;
            4'd13:        next = BRANCH;
            4'd14:        next = JUMP_LINK;
            default:      next = HALT;
          endcase
        end
      end
      EXEC_R:    next = WB_ALU;
      EXEC_I:    next = WB_ALU;
      WB_ALU:    next = resume;
      WB_IMM:    next = resume;
      MEM_ADDR:  next = (op_q == 4'd11) ? MEM_WRITE : MEM_READ;
      MEM_READ:  next = WB_MEM;
      WB_MEM:    next = resume;
      MEM_WRITE: next = resume;
      WB_CMP:    next = resume;
      BRANCH:    next = (cmpRst == BR_COND) ? PC_LOAD : resume;
      JUMP_LINK: next = PC_LOAD;
      PC_LOAD:   next = resume;
      HALT:      next = HALT;
      default:   next = IDLE;
    endcase
  end

  always_comb begin
    numBits        = '0;
    immShift       = '0;
    IRWrite        = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 1'b0;
    writeEnable    = 1'b0;
    DOrS           = 1'b0;
    memEnableWrite = 1'b0;
    memEnableRead  = 1'b0;
    PCWriteEnable  = 1'b0;
    PCSource       = 1'b0;
    memAddrSel     = 1'b0;
    ALUOp          = '0;
    regDataWrite   = '0;
    halted         = 1'b0;
    case (state)
      FETCH: begin
        memEnableRead = 1'b1;
        IRWrite       = 1'b1;
        PCWriteEnable = 1'b1;
      end
      EXEC_R: begin
        ALUOp = op_q[2:0];
        DOrS  = 1'b1;
      end
      EXEC_I: begin
        ALUSrcB = 1'b1;
        numBits = 2'd1;
      end
      WB_ALU: begin
        writeEnable = 1'b1;
        DOrS        = (op_q < 4'd8);
      end
      WB_IMM: begin
        numBits      = 2'd1;
        regDataWrite = 3'd3;
        writeEnable  = 1'b1;
      end
      MEM_ADDR: begin
        ALUSrcB = 1'b1;
        numBits = 2'd1;
      end
      MEM_READ: begin
        memAddrSel    = 1'b1;
        memEnableRead = 1'b1;
      end
      WB_MEM: begin
        regDataWrite = 3'd1;
        writeEnable  = 1'b1;
      end
      MEM_WRITE: begin
        memAddrSel     = 1'b1;
        memEnableWrite = 1'b1;
      end
      WB_CMP: begin
        regDataWrite = 3'd4;
        writeEnable  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 1'b1;
        numBits  = 2'd2;
        immShift = 2'd1;
      end
      JUMP_LINK: begin
        regDataWrite = 3'd2;
        writeEnable  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 1'b1;
        numBits      = 2'd2;
        immShift     = 2'd1;
      end
      PC_LOAD: begin
        PCSource      = 1'b1;
        PCWriteEnable = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control bundles are queued per instruction.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic [3:0] op;
  logic [1:0] cmpRst;
  logic [1:0] numBits, immShift;
  logic       IRWrite, ALUSrcA, ALUSrcB, writeEnable, DOrS;
  logic       memEnableWrite, memEnableRead, PCWriteEnable, PCSource, memAddrSel;
  logic [2:0] ALUOp, regDataWrite;
  logic       halted;
  logic [3:0] state_dbg;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;
  exp_t sb[$];

  multicycle_control #(.HALT_OP(4'hF), .BR_COND(2'b01)) dut (
    .CLK(CLK), .reset_n(reset_n), .op(op), .cmpRst(cmpRst),
    .numBits(numBits), .immShift(immShift), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .writeEnable(writeEnable),
    .DOrS(DOrS), .memEnableWrite(memEnableWrite), .memEnableRead(memEnableRead),
    .PCWriteEnable(PCWriteEnable), .PCSource(PCSource), .memAddrSel(memAddrSel),
    .ALUOp(ALUOp), .regDataWrite(regDataWrite), .halted(halted),
    .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // Bundle layout: state, numBits, immShift, IRWrite, ALUSrcA, ALUSrcB, writeEnable, DOrS,
  // memEnableWrite, memEnableRead, PCWriteEnable, PCSource, memAddrSel, ALUOp, regDataWrite, halted
  function automatic logic [24:0] ctl(input logic [3:0] st, input logic [1:0] nb, input logic [1:0] is,
                                      input logic irw, input logic asa, input logic asb, input logic we,
                                      input logic dors, input logic mew, input logic mer, input logic pcwe,
                                      input logic pcs, input logic mas, input logic [2:0] aop,
                                      input logic [2:0] rdw, input logic h);
    return {st, nb, is, irw, asa, asb, we, dors, mew, mer, pcwe, pcs, mas, aop, rdw, h};
  endfunction

  function automatic logic [24:0] obs();
    return {state_dbg, numBits, immShift, IRWrite, ALUSrcA, ALUSrcB, writeEnable, DOrS,
            memEnableWrite, memEnableRead, PCWriteEnable, PCSource, memAddrSel,
            ALUOp, regDataWrite, halted};
  endfunction

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %07h expected %07h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [24:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge CLK);
      e = sb.pop_front();
      check(e.tag, obs(), e.v);
    end
  endtask

  localparam logic [24:0] E_IDLE   = 25'd0;
  localparam logic [24:0] E_DECODE = {4'd2, 21'd0};

  task automatic push_fetch_decode(input string name);
    push({name, ".fetch"},  ctl(4'd1, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 3'd0, 0));
    push({name, ".decode"}, E_DECODE);
  endtask

  task automatic instr(input string name, input logic [3:0] o, input logic [1:0] c);
    logic [2:0] lo;
    op     = o;
    cmpRst = c;
    lo     = o[2:0];
    push_fetch_decode(name);
    if (o < 4'd8) begin
      push({name, ".exec_r"}, ctl(4'd3, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, lo, 3'd0, 0));
      push({name, ".wb_alu"}, ctl(4'd5, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0));
    end else begin
      case (o)
        4'd8: begin
          push({name, ".exec_i"}, ctl(4'd4, 2'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0));
          push({name, ".wb_alu"}, ctl(4'd5, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0));
        end
        4'd9:
          push({name, ".wb_imm"}, ctl(4'd6, 2'd1, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd3, 0));
        4'd10: begin
          push({name, ".maddr"},  ctl(4'd7, 2'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0));
          push({name, ".mread"},  ctl(4'd8, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3'd0, 3'd0, 0));
          push({name, ".wb_mem"}, ctl(4'd9, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd1, 0));
        end
        4'd11: begin
          push({name, ".maddr"},  ctl(4'd7, 2'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0));
          push({name, ".mwrite"}, ctl(4'd10, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3'd0, 3'd0, 0));
        end
        4'd12:
          push({name, ".wb_cmp"}, ctl(4'd11, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd4, 0));
        4'd13: begin
          push({name, ".branch"}, ctl(4'd12, 2'd2, 2'd1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0));
          if (c == 2'b01)
            push({name, ".pcload"}, ctl(4'd14, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3'd0, 3'd0, 0));
        end
        4'd14: begin
          push({name, ".jal"},    ctl(4'd13, 2'd2, 2'd1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd2, 0));
          push({name, ".pcload"}, ctl(4'd14, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3'd0, 3'd0, 0));
        end
        default: ;
      endcase
    end
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    op      = 4'h0;
    cmpRst  = 2'b00;
    #1 check("reset.async", obs(), E_IDLE);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("reset.hold", obs(), E_IDLE);
    end
    reset_n = 1'b1;

    instr("add",   4'h1, 2'b00);
    instr("lw",    4'hA, 2'b00);
    instr("sw",    4'hB, 2'b00);
    instr("addi",  4'h8, 2'b00);
    instr("li",    4'h9, 2'b00);
    instr("cmp",   4'hC, 2'b00);
    instr("br_t",  4'hD, 2'b01);
    instr("br_nt", 4'hD, 2'b10);
    instr("br_lt", 4'hD, 2'b00);
    instr("sra",   4'h7, 2'b00);
    instr("jal",   4'hE, 2'b00);

    op = 4'hF;
    push_fetch_decode("halt");
    for (int i = 0; i < 20; i++)
      push("halt.hold", ctl(4'd15, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 1));
    drain();
    reset_n = 1'b0;
    #1 check("halt.reset", obs(), E_IDLE);
    @(negedge CLK);
    check("halt.reset_hold", obs(), E_IDLE);
    reset_n = 1'b1;

    // Abort a load while it is reading memory; writeback must never appear.
    op = 4'hA;
    push_fetch_decode("lw_abort");
    push("lw_abort.maddr", ctl(4'd7, 2'd1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0));
    push("lw_abort.mread", ctl(4'd8, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3'd0, 3'd0, 0));
    drain();
    reset_n = 1'b0;
    #1 check("lw_abort.async", obs(), E_IDLE);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("lw_abort.idle", obs(), E_IDLE);
    end
    reset_n = 1'b1;
    instr("post_abort_add", 4'h2, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
